// File: rtl/acq_pkg.sv
// Shared definitions for the line-acquisition sequencer.
//   - acq_state_t : sequencer state encoding
//   - *_DEF       : default widths and sizes used as parameter defaults
//   - write-data field positions: {zeros, line_start_flag, inice, adc_dout}
package acq_pkg;

    localparam int unsigned ADC_DATA_W_DEF         = 10;
    localparam int unsigned DAC_DATA_W_DEF         = 10;
    localparam int unsigned DAC_GAIN_N_DEF         = 32;
    localparam int unsigned PULSER_LEN_W_DEF       = 8;
    localparam int unsigned ACQ_LINES_MAX_DEF      = 32;
    localparam int unsigned ACQ_LINES_W_DEF        = 8;
    localparam int unsigned ACQ_WORDS_PER_LINE_DEF = 16384;
    localparam int unsigned RAM_DATA_W_DEF         = 16;
    localparam int unsigned RAM_ADDR_W_DEF         = 19;
    localparam int unsigned INICE_N_DEF            = 3;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ON,
        INTER,
        OFF,
        SAMPLE,
        NEXT,
        DONE
    } acq_state_t;

    // ADC sample always sits at the bottom of the RAM word
    localparam int unsigned WDATA_ADC_LSB = 0;

    // PMOD inputs sit directly above the ADC sample
    function automatic int unsigned wdata_inice_lsb(input int unsigned adc_w);
        return WDATA_ADC_LSB + adc_w;
    endfunction

    // Line-start flag sits directly above the PMOD inputs
    function automatic int unsigned wdata_flag_bit(input int unsigned adc_w,
                                                   input int unsigned inice_n);
        return WDATA_ADC_LSB + adc_w + inice_n;
    endfunction

endpackage

// File: rtl/acq_pulser_seq.sv
// Pulser phase sequencer: walks INIT -> ON -> INTER -> OFF once per start.
// Each phase lasts max(len,1) clk cycles; lengths are read live every cycle.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse, begins INIT on the next cycle
//   *_len               phase lengths in clk ticks
//   done_c              combinational: high in the last cycle of OFF
//   pulser_on/off       registered drives, high only in ON / OFF
module acq_pulser_seq
    import acq_pkg::*;
#(
    parameter int unsigned PULSER_LEN_W = PULSER_LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PULSER_LEN_W-1:0] init_len,
    input  logic [PULSER_LEN_W-1:0] on_len,
    input  logic [PULSER_LEN_W-1:0] inter_len,
    input  logic [PULSER_LEN_W-1:0] off_len,
    output logic                    done_c,
    output logic                    pulser_on,
    output logic                    pulser_off
);

    acq_state_t              phase;
    logic [PULSER_LEN_W-1:0] cnt;
    logic [PULSER_LEN_W-1:0] cur_len;
    logic [PULSER_LEN_W-1:0] len_eff;
    logic                    phase_last;

    // Length of the current phase, with zero treated as one cycle
    always_comb begin
        cur_len    = init_len;
        len_eff    = '0;
        phase_last = 1'b0;
        case (phase)
            ON:      cur_len = on_len;
            INTER:   cur_len = inter_len;
            OFF:     cur_len = off_len;
            default: cur_len = init_len;
        endcase
        len_eff = (cur_len == '0) ? PULSER_LEN_W'(1) : cur_len;
        // >= so a length shrunk mid-phase still terminates immediately
        phase_last = (phase == INIT || phase == ON || phase == INTER || phase == OFF)
                     && (cnt >= len_eff);
    end

    assign done_c = (phase == OFF) && phase_last;

    // Phase register with registered pulser drives
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= IDLE;
            cnt        <= '0;
            pulser_on  <= 1'b0;
            pulser_off <= 1'b0;
        end else if (start) begin
            phase      <= INIT;
            cnt        <= PULSER_LEN_W'(1);
            pulser_on  <= 1'b0;
            pulser_off <= 1'b0;
        end else if (phase_last) begin
            cnt <= PULSER_LEN_W'(1);
            case (phase)
                INIT: begin
                    phase     <= ON;
                    pulser_on <= 1'b1;
                end
                ON: begin
                    phase     <= INTER;
                    pulser_on <= 1'b0;
                end
                INTER: begin
                    phase      <= OFF;
                    pulser_off <= 1'b1;
                end
                default: begin
                    phase      <= IDLE;
                    pulser_on  <= 1'b0;
                    pulser_off <= 1'b0;
                end
            endcase
        end else if (phase != IDLE) begin
            cnt <= cnt + PULSER_LEN_W'(1);
        end
    end

endmodule

// File: rtl/acq_engine.sv
// Ultrasound line-acquisition sequencer.
// Per line: pulser sequence (acq_pulser_seq), then ACQ_WORDS_PER_LINE cycles
// of ADC capture into RAM write requests while stepping the TGC gain table.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   pulser_on/off, *_len      pulser drives and live phase lengths
//   dac_din/dac_dvalid        DAC code and one-cycle strobe
//   dac_gain_ptr/dac_gain     gain-table read port (1-cycle read latency)
//   dac_idle                  DAC code outside the gain curve
//   adc_dout                  ADC sample, valid every cycle
//   acq_start/busy/done       control handshake, acq_lines = lines minus one
//   acq_waddr/wdata/wen       RAM write request
//   inice                     PMOD inputs tagged into wdata
// Build option: define ACQ_INICE_TAG_EN to place inice into wdata; otherwise
// those bits are zero and inice is ignored.
module acq_engine
    import acq_pkg::*;
#(
    parameter int unsigned ADC_DATA_W         = ADC_DATA_W_DEF,
    parameter int unsigned DAC_DATA_W         = DAC_DATA_W_DEF,
    parameter int unsigned DAC_GAIN_N         = DAC_GAIN_N_DEF,
    parameter int unsigned DAC_GAIN_PTR_W     = $clog2(DAC_GAIN_N),
    parameter int unsigned PULSER_LEN_W       = PULSER_LEN_W_DEF,
    parameter int unsigned ACQ_LINES_MAX      = ACQ_LINES_MAX_DEF,
    parameter int unsigned ACQ_LINES_W        = ACQ_LINES_W_DEF,
    parameter int unsigned ACQ_WORDS_PER_LINE = ACQ_WORDS_PER_LINE_DEF,
    parameter int unsigned RAM_DATA_W         = RAM_DATA_W_DEF,
    parameter int unsigned RAM_ADDR_W         = RAM_ADDR_W_DEF,
    parameter int unsigned INICE_N            = INICE_N_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      pulser_on,
    output logic                      pulser_off,
    input  logic [PULSER_LEN_W-1:0]   pulser_on_len,
    input  logic [PULSER_LEN_W-1:0]   pulser_off_len,
    input  logic [PULSER_LEN_W-1:0]   pulser_init_len,
    input  logic [PULSER_LEN_W-1:0]   pulser_inter_len,
    output logic [DAC_DATA_W-1:0]     dac_din,
    output logic                      dac_dvalid,
    output logic [DAC_GAIN_PTR_W-1:0] dac_gain_ptr,
    input  logic [DAC_DATA_W-1:0]     dac_gain,
    input  logic [DAC_DATA_W-1:0]     dac_idle,
    input  logic [ADC_DATA_W-1:0]     adc_dout,
    input  logic                      acq_start,
    output logic                      acq_busy,
    output logic                      acq_done,
    input  logic [ACQ_LINES_W-1:0]    acq_lines,
    output logic [RAM_ADDR_W-1:0]     acq_waddr,
    output logic [RAM_DATA_W-1:0]     acq_wdata,
    output logic                      acq_wen,
    input  logic [INICE_N-1:0]        inice
);

    localparam int unsigned WORD_W    = $clog2(ACQ_WORDS_PER_LINE);
    localparam int unsigned SEG       = ACQ_WORDS_PER_LINE / DAC_GAIN_N;
    localparam int unsigned SEG_W     = $clog2(SEG);
    localparam int unsigned INICE_LSB = wdata_inice_lsb(ADC_DATA_W);
    localparam int unsigned FLAG_BIT  = wdata_flag_bit(ADC_DATA_W, INICE_N);
    localparam logic [ACQ_LINES_W-1:0] LAST_LINE_MAX = ACQ_LINES_W'(ACQ_LINES_MAX - 1);

    acq_state_t               state;
    logic [ACQ_LINES_W-1:0]   line;
    logic [ACQ_LINES_W-1:0]   last_line;
    logic [WORD_W-1:0]        word;
    logic                     gain_upd_q1;
    logic                     gain_upd_q2;
    logic                     pwrup_pend;
    logic                     seq_start_c;
    logic                     seq_done_c;
    logic                     word_last_c;
    logic                     gain_step_c;
    logic [RAM_DATA_W-1:0]    wdata_nxt_c;

    // Pulser sub-sequencer; the top sits in INIT for the whole pulse sequence
    acq_pulser_seq #(
        .PULSER_LEN_W (PULSER_LEN_W)
    ) u_pulser_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (seq_start_c),
        .init_len   (pulser_init_len),
        .on_len     (pulser_on_len),
        .inter_len  (pulser_inter_len),
        .off_len    (pulser_off_len),
        .done_c     (seq_done_c),
        .pulser_on  (pulser_on),
        .pulser_off (pulser_off)
    );

    // Line-start decisions and gain-step points
    always_comb begin
        seq_start_c = 1'b0;
        if (!rst) begin
            if (state == IDLE && acq_start) begin
                seq_start_c = 1'b1;
            end
            if (state == NEXT && line != last_line) begin
                seq_start_c = 1'b1;
            end
        end
        word_last_c = (word == WORD_W'(ACQ_WORDS_PER_LINE - 1));
        // Pointer changes on the edge into word k*SEG so it is visible at w=k*SEG
        gain_step_c = (word[SEG_W-1:0] == SEG_W'(SEG - 1)) && !word_last_c;
    end

    // Write-data word: {zeros, line_start_flag, inice, adc_dout}
    always_comb begin
        wdata_nxt_c = '0;
        wdata_nxt_c[WDATA_ADC_LSB +: ADC_DATA_W] = adc_dout;
`ifdef ACQ_INICE_TAG_EN
        wdata_nxt_c[INICE_LSB +: INICE_N] = inice;
`endif
        wdata_nxt_c[FLAG_BIT] = (word == '0);
    end

`ifndef ACQ_INICE_TAG_EN
    logic unused_inice;
    assign unused_inice = ^inice;
`endif

    // Main sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            line         <= '0;
            last_line    <= '0;
            word         <= '0;
            gain_upd_q1  <= 1'b0;
            gain_upd_q2  <= 1'b0;
            pwrup_pend   <= 1'b1;
            dac_din      <= dac_idle;
            dac_dvalid   <= 1'b0;
            dac_gain_ptr <= '0;
            acq_busy     <= 1'b0;
            acq_done     <= 1'b0;
            acq_waddr    <= '0;
            acq_wdata    <= '0;
            acq_wen      <= 1'b0;
        end else begin
            acq_done    <= 1'b0;
            acq_wen     <= 1'b0;
            dac_dvalid  <= 1'b0;
            gain_upd_q1 <= 1'b0;
            gain_upd_q2 <= gain_upd_q1;
            pwrup_pend  <= 1'b0;

            // Table data for a pointer set two edges ago is valid now
            if (gain_upd_q2) begin
                dac_din    <= dac_gain;
                dac_dvalid <= 1'b1;
            end

            // Park the DAC at its idle code once after reset
            if (pwrup_pend) begin
                dac_din    <= dac_idle;
                dac_dvalid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (acq_start) begin
                        last_line    <= (acq_lines >= LAST_LINE_MAX) ? LAST_LINE_MAX : acq_lines;
                        line         <= '0;
                        acq_busy     <= 1'b1;
                        dac_gain_ptr <= '0;
                        gain_upd_q1  <= 1'b1;
                        state        <= INIT;
                    end
                end

                INIT: begin
                    if (seq_done_c) begin
                        word  <= '0;
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    acq_wen   <= 1'b1;
                    acq_waddr <= RAM_ADDR_W'({line, word});
                    acq_wdata <= wdata_nxt_c;
                    word      <= word + WORD_W'(1);
                    if (gain_step_c) begin
                        dac_gain_ptr <= dac_gain_ptr + DAC_GAIN_PTR_W'(1);
                        gain_upd_q1  <= 1'b1;
                    end
                    if (word_last_c) begin
                        state <= NEXT;
                    end
                end

                NEXT: begin
                    line <= line + ACQ_LINES_W'(1);
                    if (line == last_line) begin
                        acq_done   <= 1'b1;
                        dac_din    <= dac_idle;
                        dac_dvalid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        dac_gain_ptr <= '0;
                        gain_upd_q1  <= 1'b1;
                        state        <= INIT;
                    end
                end

                DONE: begin
                    acq_busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_engine.sv
// Self-checking bench for acq_engine with 64 words/line and a 4-entry gain table.
module tb_acq_engine;

    localparam int WPL     = 64;
    localparam int GN      = 4;
    localparam int SEGW    = WPL / GN;
    localparam int LMAX    = 32;
    localparam logic [9:0] IDLE_CODE = 10'h100;

    typedef struct {
        logic [18:0] addr;
        logic [15:0] data;
        logic [9:0]  adc;
        logic [2:0]  ice;
        logic [1:0]  ptr;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        pulser_on, pulser_off;
    logic [7:0]  pulser_on_len, pulser_off_len, pulser_init_len, pulser_inter_len;
    logic [9:0]  dac_din;
    logic        dac_dvalid;
    logic [1:0]  dac_gain_ptr;
    logic [9:0]  dac_gain;
    logic [9:0]  dac_idle;
    logic [9:0]  adc_dout;
    logic        acq_start, acq_busy, acq_done;
    logic [7:0]  acq_lines;
    logic [18:0] acq_waddr;
    logic [15:0] acq_wdata;
    logic        acq_wen;
    logic [2:0]  inice;

    int n_cmp = 0;
    int n_bad = 0;
    bit ice_rand = 0;

    // monitor records
    int  cyc = 0;
    int  busy_rise, done_cyc, done_cnt, done_err, both_hi;
    int  on_rise[$], on_fall[$], off_rise[$], off_fall[$], wen_rise[$];
    logic [9:0] dv_q[$];
    wr_t wr_q[$];

    acq_engine #(
        .ADC_DATA_W(10), .DAC_DATA_W(10), .DAC_GAIN_N(GN), .DAC_GAIN_PTR_W(2),
        .PULSER_LEN_W(8), .ACQ_LINES_MAX(LMAX), .ACQ_LINES_W(8),
        .ACQ_WORDS_PER_LINE(WPL), .RAM_DATA_W(16), .RAM_ADDR_W(19), .INICE_N(3)
    ) dut (
        .clk(clk), .rst(rst),
        .pulser_on(pulser_on), .pulser_off(pulser_off),
        .pulser_on_len(pulser_on_len), .pulser_off_len(pulser_off_len),
        .pulser_init_len(pulser_init_len), .pulser_inter_len(pulser_inter_len),
        .dac_din(dac_din), .dac_dvalid(dac_dvalid), .dac_gain_ptr(dac_gain_ptr),
        .dac_gain(dac_gain), .dac_idle(dac_idle), .adc_dout(adc_dout),
        .acq_start(acq_start), .acq_busy(acq_busy), .acq_done(acq_done),
        .acq_lines(acq_lines), .acq_waddr(acq_waddr), .acq_wdata(acq_wdata),
        .acq_wen(acq_wen), .inice(inice)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gain table: entry i = 0x200+i, one-cycle registered read
    initial begin
        dac_gain = '0;
        forever begin
            @(posedge clk);
            dac_gain <= 10'h200 + 10'(dac_gain_ptr);
        end
    end

    // ADC ramp from a random seed; PMOD pins fixed or random
    initial begin
        adc_dout = 10'($urandom);
        inice    = 3'b101;
        forever begin
            @(negedge clk);
            #1;
            adc_dout = adc_dout + 10'd1;
            inice    = ice_rand ? 3'($urandom) : 3'b101;
        end
    end

    // Event recorder, sampled on the falling edge
    initial begin
        logic p_on, p_off, p_wen, p_done;
        wr_t  w;
        p_on = 0; p_off = 0; p_wen = 0; p_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pulser_on === 1'b1 && !p_on) on_rise.push_back(cyc);
            if (pulser_on === 1'b0 && p_on)  on_fall.push_back(cyc);
            if (pulser_off === 1'b1 && !p_off) off_rise.push_back(cyc);
            if (pulser_off === 1'b0 && p_off)  off_fall.push_back(cyc);
            if (acq_wen === 1'b1 && !p_wen) wen_rise.push_back(cyc);
            if (acq_busy === 1'b1 && busy_rise < 0) busy_rise = cyc;
            if (pulser_on === 1'b1 && pulser_off === 1'b1) both_hi++;
            if (dac_dvalid === 1'b1) dv_q.push_back(dac_din);
            if (acq_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (dac_dvalid !== 1'b1 || dac_din !== IDLE_CODE || acq_busy !== 1'b1) done_err++;
            end
            if (p_done && acq_busy !== 1'b0) done_err++;
            if (acq_wen === 1'b1) begin
                w.addr = acq_waddr; w.data = acq_wdata; w.adc = adc_dout;
                w.ice = inice; w.ptr = dac_gain_ptr;
                wr_q.push_back(w);
            end
            p_on   = (pulser_on === 1'b1);
            p_off  = (pulser_off === 1'b1);
            p_wen  = (acq_wen === 1'b1);
            p_done = (acq_done === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        busy_rise = -1; done_cyc = 0; done_cnt = 0; done_err = 0; both_hi = 0;
        on_rise.delete(); on_fall.delete(); off_rise.delete(); off_fall.delete();
        wen_rise.delete(); dv_q.delete(); wr_q.delete();
    endtask

    function automatic int eff(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    // One complete acquisition, then compare everything recorded against the model
    task automatic run_acq(input int lines, input int il, input int onl,
                           input int itl, input int ofl, input bit mid_start);
        int L, nw, n, budget;
        int e_addr, e_flag, e_adc, e_ice, e_hi, e_ptr, e_dv;
        int e_on, e_off, e_gap, e_wen, e_line;
        int w, pe;
        logic [9:0] exp_dv[$];
        L = (lines + 1 > LMAX) ? LMAX : lines + 1;
        nw = L * WPL;
        clear_mon();
        @(negedge clk);
        pulser_init_len = 8'(il); pulser_on_len = 8'(onl);
        pulser_inter_len = 8'(itl); pulser_off_len = 8'(ofl);
        acq_lines = 8'(lines);
        acq_start = 1'b1;
        @(negedge clk);
        acq_start = 1'b0;
        budget = L * 1200 + 100;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (mid_start && n == 200) begin
                acq_start = 1'b1;
                acq_lines = 8'd0;
            end else begin
                acq_start = 1'b0;
            end
        end
        check("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);

        check("done_count", 64'(done_cnt), 64'd1);
        check("done_err", 64'(done_err), 64'd0);
        check("busy_after", 64'(acq_busy), 64'd0);
        check("both_high", 64'(both_hi), 64'd0);
        check("wr_count", 64'(wr_q.size()), 64'(nw));
        if (wr_q.size() > 0)
            check("last_addr", 64'(wr_q[wr_q.size()-1].addr), 64'(nw - 1));

        e_addr = 0; e_flag = 0; e_adc = 0; e_ice = 0; e_hi = 0; e_ptr = 0;
        foreach (wr_q[i]) begin
            w  = i % WPL;
            pe = (w + 1) / SEGW;
            if (pe > GN - 1) pe = GN - 1;
            if (wr_q[i].addr !== 19'(i)) e_addr++;
            if (wr_q[i].data[13] !== (w == 0)) e_flag++;
            if (wr_q[i].data[9:0] !== wr_q[i].adc) e_adc++;
`ifdef ACQ_INICE_TAG_EN
            if (wr_q[i].data[12:10] !== wr_q[i].ice) e_ice++;
`else
            if (wr_q[i].data[12:10] !== 3'b000) e_ice++;
`endif
            if (wr_q[i].data[15:14] !== 2'b00) e_hi++;
            if (wr_q[i].ptr !== 2'(pe)) e_ptr++;
        end
        check("wr_addr_err", 64'(e_addr), 64'd0);
        check("wr_flag_err", 64'(e_flag), 64'd0);
        check("wr_adc_err", 64'(e_adc), 64'd0);
        check("wr_inice_err", 64'(e_ice), 64'd0);
        check("wr_upper_err", 64'(e_hi), 64'd0);
        check("gain_ptr_err", 64'(e_ptr), 64'd0);

        for (int l = 0; l < L; l++)
            for (int k = 0; k < GN; k++) exp_dv.push_back(10'(10'h200 + k));
        exp_dv.push_back(IDLE_CODE);
        check("dvalid_count", 64'(dv_q.size()), 64'(exp_dv.size()));
        e_dv = 0;
        foreach (exp_dv[i]) if (i >= dv_q.size() || dv_q[i] !== exp_dv[i]) e_dv++;
        check("dvalid_values", 64'(e_dv), 64'd0);

        check("on_pulses", 64'(on_rise.size()), 64'(L));
        check("off_pulses", 64'(off_fall.size()), 64'(L));
        check("wen_bursts", 64'(wen_rise.size()), 64'(L));
        if (on_rise.size() > 0)
            check("init_delay", 64'(on_rise[0] - busy_rise), 64'(eff(il)));
        e_on = 0; e_off = 0; e_gap = 0; e_wen = 0; e_line = 0;
        for (int i = 0; i < L; i++) begin
            if (i < on_rise.size() && i < on_fall.size() && i < off_rise.size() &&
                i < off_fall.size() && i < wen_rise.size()) begin
                if (on_fall[i] - on_rise[i] != eff(onl)) e_on++;
                if (off_fall[i] - off_rise[i] != eff(ofl)) e_off++;
                if (off_rise[i] - on_fall[i] != eff(itl)) e_gap++;
                if (wen_rise[i] - off_fall[i] != 1) e_wen++;
                if (i > 0 && on_rise[i] - wen_rise[i-1] != WPL + eff(il)) e_line++;
            end
        end
        check("on_len_err", 64'(e_on), 64'd0);
        check("off_len_err", 64'(e_off), 64'd0);
        check("inter_gap_err", 64'(e_gap), 64'd0);
        check("sample_start_err", 64'(e_wen), 64'd0);
        check("line_period_err", 64'(e_line), 64'd0);
        if (wen_rise.size() > 0)
            check("done_timing", 64'(done_cyc - wen_rise[wen_rise.size()-1]), 64'(WPL));
    endtask

    initial begin
        int n;
        rst = 1'b1; acq_start = 1'b0; acq_lines = '0; dac_idle = IDLE_CODE;
        pulser_on_len = '0; pulser_off_len = '0; pulser_init_len = '0; pulser_inter_len = '0;
        repeat (3) @(negedge clk);

        check("rst_pulser_on", 64'(pulser_on), 64'd0);
        check("rst_pulser_off", 64'(pulser_off), 64'd0);
        check("rst_dvalid", 64'(dac_dvalid), 64'd0);
        check("rst_din", 64'(dac_din), 64'(IDLE_CODE));
        check("rst_ptr", 64'(dac_gain_ptr), 64'd0);
        check("rst_busy", 64'(acq_busy), 64'd0);
        check("rst_done", 64'(acq_done), 64'd0);
        check("rst_waddr", 64'(acq_waddr), 64'd0);
        check("rst_wdata", 64'(acq_wdata), 64'd0);
        check("rst_wen", 64'(acq_wen), 64'd0);

        rst = 1'b0;
        @(negedge clk);
        check("pwrup_dvalid", 64'(dac_dvalid), 64'd1);
        check("pwrup_din", 64'(dac_din), 64'(IDLE_CODE));
        @(negedge clk);
        check("pwrup_single", 64'(dac_dvalid), 64'd0);

        run_acq(1, 12, 31, 12, 255, 1'b0);
        run_acq(40, 3, 2, 1, 4, 1'b1);
        run_acq(2, 0, 0, 0, 0, 1'b0);

        ice_rand = 1'b1;
        for (int r = 0; r < 3; r++)
            run_acq(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 20)), 1'b0);

        // Reset in the middle of SAMPLE
        clear_mon();
        @(negedge clk);
        pulser_init_len = 8'd4; pulser_on_len = 8'd4;
        pulser_inter_len = 8'd4; pulser_off_len = 8'd4;
        acq_lines = 8'd0; acq_start = 1'b1;
        @(negedge clk);
        acq_start = 1'b0;
        n = 0;
        while (wr_q.size() < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_sample", 64'(wr_q.size() >= 10), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wen", 64'(acq_wen), 64'd0);
        check("mid_rst_busy", 64'(acq_busy), 64'd0);
        check("mid_rst_waddr", 64'(acq_waddr), 64'd0);
        check("mid_rst_wdata", 64'(acq_wdata), 64'd0);
        check("mid_rst_ptr", 64'(dac_gain_ptr), 64'd0);
        check("mid_rst_dvalid", 64'(dac_dvalid), 64'd0);
        check("mid_rst_din", 64'(dac_din), 64'(IDLE_CODE));
        rst = 1'b0;
        @(negedge clk);
        check("mid_pwrup_dvalid", 64'(dac_dvalid), 64'd1);
        @(negedge clk);
        check("mid_idle_busy", 64'(acq_busy), 64'd0);

        run_acq(0, 5, 5, 5, 5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
